// File: rtl/mine_placer_lcg_if.sv
`default_nettype none
// mine_placer_lcg_if: start/busy/done handshake and placement inputs between game control and mine placer.
// Rev 1.0
interface mine_placer_lcg_if #(
  parameter int CELLS  = 25,
  parameter int IDX_W  = 5,
  parameter int SEED_W = 16,
  parameter int CNT_W  = 5
);
  logic              in_start;
  logic [SEED_W-1:0] in_seed;
  logic [SEED_W-1:0] in_mult;
  logic [SEED_W-1:0] in_increment;
  logic [CNT_W-1:0]  in_mines_num;
  logic              in_safe_en;
  logic [IDX_W-1:0]  in_safe_idx;
  logic              out_busy;
  logic              out_done;
  logic [CELLS-1:0]  out_mines;

  modport master (
    output in_start, in_seed, in_mult, in_increment, in_mines_num, in_safe_en, in_safe_idx,
    input  out_busy, out_done, out_mines
  );

  modport slave (
    input  in_start, in_seed, in_mult, in_increment, in_mines_num, in_safe_en, in_safe_idx,
    output out_busy, out_done, out_mines
  );
endinterface
`default_nettype wire

// File: rtl/mine_placer_lcg.sv
`default_nettype none
// mine_placer_lcg: places exactly N mines using an LCG with reject sampling and linear probing.
// Rev 1.0
module mine_placer_lcg #(
  parameter int CELLS  = 25,
  parameter int IDX_W  = 5,
  parameter int SEED_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic               in_clka,
  input  logic               in_rst_n,
  mine_placer_lcg_if.slave   bus
);
  localparam int LIM_W = (CNT_W > IDX_W + 1) ? CNT_W : IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAW  = 3'd2,
    S_PROBE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SEED_W-1:0] x_q, x_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [SEED_W-1:0] mult_q, mult_d;
  logic [SEED_W-1:0] incr_q, incr_d;
  logic [LIM_W-1:0]  limit_q, limit_d;
  logic [LIM_W-1:0]  count_q, count_d;
  logic              safe_en_q, safe_en_d;
  logic [IDX_W-1:0]  safe_idx_q, safe_idx_d;
  logic [IDX_W-1:0]  probe_q, probe_d;
  logic [CELLS-1:0]  map_q, map_d;
  logic [CELLS-1:0]  mines_q, mines_d;

  logic              safe_ok;
  logic [LIM_W-1:0]  req_cnt;
  logic [LIM_W-1:0]  cap_cnt;
  logic [LIM_W-1:0]  new_limit;
  logic [SEED_W-1:0] x_step;
  logic [IDX_W-1:0]  cand;
  logic              cand_in_range;
  logic              cand_free;
  logic              probe_free;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(CELLS - 1)) ? '0 : i + 1'b1;
  endfunction

  // An out-of-range safe index cannot exclude anything, so it must not shrink the clamp either.
  assign safe_ok   = bus.in_safe_en && ({1'b0, bus.in_safe_idx} < (IDX_W + 1)'(CELLS));
  assign req_cnt   = LIM_W'(bus.in_mines_num);
  assign cap_cnt   = LIM_W'(CELLS) - LIM_W'(safe_ok);
  assign new_limit = (req_cnt < cap_cnt) ? req_cnt : cap_cnt;

  assign x_step        = mult_q * x_q + incr_q;
  assign cand          = x_step[SEED_W-1 -: IDX_W];
  assign cand_in_range = ({1'b0, cand} < (IDX_W + 1)'(CELLS));
  assign cand_free     = !map_q[cand] && !(safe_en_q && (cand == safe_idx_q));
  assign probe_free    = !map_q[probe_q] && !(safe_en_q && (probe_q == safe_idx_q));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    seed_d     = seed_q;
    mult_d     = mult_q;
    incr_d     = incr_q;
    limit_d    = limit_q;
    count_d    = count_q;
    safe_en_d  = safe_en_q;
    safe_idx_d = safe_idx_q;
    probe_d    = probe_q;
    map_d      = map_q;
    mines_d    = mines_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.in_start) begin
          seed_d     = bus.in_seed;
          mult_d     = bus.in_mult;
          incr_d     = bus.in_increment;
          limit_d    = new_limit;
          safe_en_d  = safe_ok;
          safe_idx_d = bus.in_safe_idx;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        map_d   = '0;
        count_d = '0;
        x_d     = seed_q;
        state_d = (limit_q == '0) ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        x_d = x_step;
        if (cand_in_range) begin
          if (cand_free) begin
            map_d[cand] = 1'b1;
            count_d     = count_q + 1'b1;
            if (count_d == limit_q) state_d = S_DONE;
          end else begin
            probe_d = next_idx(cand);
            state_d = S_PROBE;
          end
        end
      end
      S_PROBE: begin
        if (probe_free) begin
          map_d[probe_q] = 1'b1;
          count_d        = count_q + 1'b1;
          state_d        = (count_d == limit_q) ? S_DONE : S_DRAW;
        end else begin
          probe_d = next_idx(probe_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Publish only complete maps, captured on the edge that enters DONE.
    if ((state_d == S_DONE) && (state_q != S_DONE)) mines_d = map_d;
  end

  always_ff @(posedge in_clka or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      seed_q     <= '0;
      mult_q     <= '0;
      incr_q     <= '0;
      limit_q    <= '0;
      count_q    <= '0;
      safe_en_q  <= 1'b0;
      safe_idx_q <= '0;
      probe_q    <= '0;
      map_q      <= '0;
      mines_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      seed_q     <= seed_d;
      mult_q     <= mult_d;
      incr_q     <= incr_d;
      limit_q    <= limit_d;
      count_q    <= count_d;
      safe_en_q  <= safe_en_d;
      safe_idx_q <= safe_idx_d;
      probe_q    <= probe_d;
      map_q      <= map_d;
      mines_q    <= mines_d;
    end
  end

  assign bus.out_busy  = (state_q == S_LOAD) || (state_q == S_DRAW) || (state_q == S_PROBE);
  assign bus.out_done  = (state_q == S_DONE);
  assign bus.out_mines = mines_q;
endmodule
`default_nettype wire
